clb_cfg: RTL and testbench

- Parametrised second-generation configurable logic block: NUM_LUT look-up tables of LUT_K inputs each, with one optional register per LUT.
- Configuration arrives over a serial shift chain instead of fixed initial values, so bitstreams can be loaded and reloaded at run time.
- Each LUT input is routed by a per-input selector from the primary inputs or from the registered feedback outputs.
- Tiles chain to their neighbours through cfg_dout to form a device-level configuration chain.

---
 rtl/clb_cfg_pkg.sv | 36 +++
 rtl/clb_lut_cell.sv | 74 +++++++
 rtl/clb_cfg.sv | 122 ++++++++++++
 tb/tb_clb_cfg.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared types and field-layout helpers for the serially configured logic block.
// Latency: n/a (types, constants and constant functions only).
// Backpressure: n/a.
package clb_cfg_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2
  } clb_state_t;

  // Per-LUT field layout, LSB first: mem, sel[LUT_K], bypass, init, ce_use.
  // mem always starts at bit 0. The three single-bit flags follow the
  // select fields and are given relative to the end of those fields.
  localparam int OFF_MEM        = 0;
  localparam int OFF_BYPASS_REL = 0;
  localparam int OFF_INIT_REL   = 1;
  localparam int OFF_CE_USE_REL = 2;

  function automatic int calc_sw(input int num_in, input int num_lut);
    return $clog2(num_in + num_lut);
  endfunction

  function automatic int off_sel(input int k);
    return 1 << k;
  endfunction

  function automatic int off_flags(input int k, input int sw);
    return (1 << k) + k * sw;
  endfunction

  function automatic int calc_lut_bits(input int k, input int sw);
    return off_flags(k, sw) + 3;
  endfunction

endpackage

// File: rtl/clb_lut_cell.sv
// One LUT slice: LUT_K input selectors, 2**LUT_K:1 LUT mux, optional register, bypass mux.
// Latency: F is combinational; the registered path updates one K edge later.
// Backpressure: none; the register honours the global clock enable when ce_use is set.
// Ports: K/rst_n clock and sync reset; i_mem/i_sel/i_bypass/i_ce_use field values;
//   i_init init bit as it stands after the current edge; i_din primary inputs;
//   i_q_all registered outputs of every cell; i_enter_run/i_stay_run/i_run FSM
//   qualifiers; o_q register; o_dout slice output.
module clb_lut_cell
  import clb_cfg_pkg::*;
#(
  parameter int LUT_K   = 4,
  parameter int NUM_IN  = 4,
  parameter int NUM_LUT = 2,
  parameter int SW      = calc_sw(NUM_IN, NUM_LUT)
) (
  input  logic                  K,
  input  logic                  rst_n,
  input  logic [(1<<LUT_K)-1:0] i_mem,
  input  logic [LUT_K*SW-1:0]   i_sel,
  input  logic                  i_bypass,
  input  logic                  i_init,
  input  logic                  i_ce_use,
  input  logic [NUM_IN-1:0]     i_din,
  input  logic [NUM_LUT-1:0]    i_q_all,
  input  logic                  i_ce,
  input  logic                  i_enter_run,
  input  logic                  i_stay_run,
  input  logic                  i_run,
  output logic                  o_q,
  output logic                  o_dout
);

  localparam int NSRC = 1 << SW;

  logic [NSRC-1:0]  w_src;
  logic [LUT_K-1:0] w_addr;
  logic             w_f;
  logic             r_q;

  // Source codes past the last feedback output read the zero padding.
  always_comb begin
    w_src = '0;
    w_src[NUM_IN+NUM_LUT-1:0] = {i_q_all, i_din};
  end

  always_comb begin
    w_addr = '0;
    for (int j = 0; j < LUT_K; j++) begin
      w_addr[j] = w_src[i_sel[j*SW +: SW]];
    end
  end

  // Feedback only ever comes from registered Q, so bypassed cells cannot
  // form a combinational loop.
  assign w_f = i_mem[w_addr];

  always_ff @(posedge K) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (i_enter_run) begin
      r_q <= i_init;
    end else if (i_stay_run) begin
      if (i_ce | ~i_ce_use) begin
        r_q <= w_f;
      end
    end else begin
      r_q <= 1'b0;
    end
  end

  assign o_q    = r_q;
  assign o_dout = i_run ? (i_bypass ? w_f : r_q) : 1'b0;

endmodule

// File: rtl/clb_cfg.sv
// Configurable logic block of NUM_LUT LUT slices loaded through a serial shift chain.
// Latency: cfg_done rises on the CFG_BITS-th shift edge; dout is combinational (bypass) or one edge (registered).
// Backpressure: none; cfg_en gaps pause the load and hold the bit count.
// Ports: K clock; rst_n sync active-low reset; din primary inputs; ce register enable;
//   cfg_en/cfg_din shift chain input; cfg_dout chain bit 0; cfg_done running flag;
//   dout one output per LUT.
module clb_cfg
  import clb_cfg_pkg::*;
#(
  parameter int LUT_K   = 4,
  parameter int NUM_LUT = 2,
  parameter int NUM_IN  = 4
) (
  input  logic               K,
  input  logic               rst_n,
  input  logic [NUM_IN-1:0]  din,
  input  logic               ce,
  input  logic               cfg_en,
  input  logic               cfg_din,
  output logic               cfg_dout,
  output logic               cfg_done,
  output logic [NUM_LUT-1:0] dout
);

  localparam int SW       = calc_sw(NUM_IN, NUM_LUT);
  localparam int LUT_BITS = calc_lut_bits(LUT_K, SW);
  localparam int CFG_BITS = NUM_LUT * LUT_BITS;
  localparam int CW       = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(CFG_BITS - 1);

  logic [CFG_BITS-1:0] r_chain;
  logic [CFG_BITS-1:0] w_chain_nxt;
  clb_state_t          r_state;
  clb_state_t          w_state_nxt;
  logic [CW-1:0]       r_bitcnt;
  logic [CW-1:0]       w_bitcnt_nxt;
  logic [NUM_LUT-1:0]  w_q;
  logic                w_enter_run;
  logic                w_stay_run;
  logic                w_run;

  // First bit shifted in travels down to chain[0] after CFG_BITS shifts.
  assign w_chain_nxt = cfg_en ? {cfg_din, r_chain[CFG_BITS-1:1]} : r_chain;

  always_ff @(posedge K) begin
    if (!rst_n) begin
      r_chain  <= '0;
      r_state  <= UNCONF;
      r_bitcnt <= '0;
    end else begin
      r_chain  <= w_chain_nxt;
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
    end
  end

  // The shift that leaves UNCONF or RUN is itself counted, hence the count of 1.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    case (r_state)
      UNCONF, RUN: begin
        if (cfg_en) begin
          w_state_nxt  = LOAD;
          w_bitcnt_nxt = CW'(1);
        end
      end
      LOAD: begin
        if (cfg_en) begin
          if (r_bitcnt == LAST_CNT) begin
            w_state_nxt  = RUN;
            w_bitcnt_nxt = '0;
          end else begin
            w_bitcnt_nxt = r_bitcnt + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt  = UNCONF;
        w_bitcnt_nxt = '0;
      end
    endcase
  end

  assign w_run       = (r_state == RUN);
  assign w_enter_run = (r_state != RUN) && (w_state_nxt == RUN);
  assign w_stay_run  = w_run && (w_state_nxt == RUN);

  assign cfg_dout = r_chain[0];
  assign cfg_done = w_run;

  for (genvar gi = 0; gi < NUM_LUT; gi++) begin : g_lut
    localparam int BASE  = gi * LUT_BITS;
    localparam int FLAGS = BASE + off_flags(LUT_K, SW);

    // init is taken from the post-shift chain so the RUN entry edge loads
    // the bit that arrives with the final shift.
    clb_lut_cell #(
      .LUT_K   (LUT_K),
      .NUM_IN  (NUM_IN),
      .NUM_LUT (NUM_LUT),
      .SW      (SW)
    ) u_cell (
      .K           (K),
      .rst_n       (rst_n),
      .i_mem       (r_chain[BASE + OFF_MEM +: (1 << LUT_K)]),
      .i_sel       (r_chain[BASE + off_sel(LUT_K) +: LUT_K*SW]),
      .i_bypass    (r_chain[FLAGS + OFF_BYPASS_REL]),
      .i_init      (w_chain_nxt[FLAGS + OFF_INIT_REL]),
      .i_ce_use    (r_chain[FLAGS + OFF_CE_USE_REL]),
      .i_din       (din),
      .i_q_all     (w_q),
      .i_ce        (ce),
      .i_enter_run (w_enter_run),
      .i_stay_run  (w_stay_run),
      .i_run       (w_run),
      .o_q         (w_q[gi]),
      .o_dout      (dout[gi])
    );
  end

endmodule

// File: tb/tb_clb_cfg.sv
// Self-checking bench for clb_cfg at default parameters (62-bit chain).
// Latency: n/a.
// Backpressure: n/a.
module tb_clb_cfg;

  logic       K = 1'b0;
  logic       rst_n;
  logic [3:0] din;
  logic       ce;
  logic       cfg_en;
  logic       cfg_din;
  logic       cfg_dout;
  logic       cfg_done;
  logic [1:0] dout;

  int n_cmp = 0;
  int n_bad = 0;

  logic       chain_q[$];   // reference chain, front is chain[0]
  logic [1:0] exp_q[$];     // expected dout values awaiting comparison

  logic [61:0] bs_a;
  logic [61:0] bs_b;
  logic [61:0] bs_c;

  clb_cfg u_dut (
    .K        (K),
    .rst_n    (rst_n),
    .din      (din),
    .ce       (ce),
    .cfg_en   (cfg_en),
    .cfg_din  (cfg_din),
    .cfg_dout (cfg_dout),
    .cfg_done (cfg_done),
    .dout     (dout)
  );

  always #5 K = ~K;

  function automatic logic [30:0] mk_lut(input logic [15:0] mem,
                                         input logic [2:0] s0, input logic [2:0] s1,
                                         input logic [2:0] s2, input logic [2:0] s3,
                                         input logic byp, input logic init, input logic ceu);
    return {ceu, init, byp, s3, s2, s1, s0, mem};
  endfunction

  task automatic tick();
    @(posedge K);
    #1;
  endtask

  task automatic model_reset();
    chain_q.delete();
    for (int i = 0; i < 62; i++) chain_q.push_back(1'b0);
  endtask

  task automatic shift_bit(input logic b);
    cfg_en  = 1'b1;
    cfg_din = b;
    tick();
    cfg_en  = 1'b0;
    chain_q.push_back(b);
    void'(chain_q.pop_front());
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_en = 1'b0; cfg_din = 1'b0; ce = 1'b0; din = 4'b0000;
    repeat (3) tick();
    rst_n = 1'b1;
    model_reset();
    repeat (10) tick();
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", cfg_done); end
    n_cmp++; if (dout !== 2'b00) begin n_bad++; $display("FAIL reset_dout: got %b want 00", dout); end
    n_cmp++; if (cfg_dout !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_dout: got %b want 0", cfg_dout); end
  endtask

  task automatic test_comb_load();
    logic [3:0] pats [5];
    logic [1:0] exps [5];
    logic [1:0] e;
    pats = '{4'b1011, 4'b1111, 4'b0000, 4'b0110, 4'b0111};
    exps = '{2'b01,   2'b10,   2'b00,   2'b00,   2'b01};
    for (int i = 0; i < 62; i++) begin
      shift_bit(bs_a[i]);
      n_cmp++; if (cfg_done !== (i == 61)) begin n_bad++; $display("FAIL load_a_done shift %0d: got %b want %b", i + 1, cfg_done, (i == 61)); end
      n_cmp++; if (cfg_dout !== chain_q[0]) begin n_bad++; $display("FAIL load_a_cfg_dout shift %0d: got %b want %b", i + 1, cfg_dout, chain_q[0]); end
    end
    for (int p = 0; p < 5; p++) begin
      din = pats[p];
      exp_q.push_back(exps[p]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL comb_dout din=%b: got %b want %b", pats[p], dout, e); end
    end
  endtask

  task automatic test_registered_toggle();
    logic q0;
    logic q1;
    logic [1:0] e;
    ce = 1'b0;
    shift_bit(bs_b[0]);
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL reconf_done: got %b want 0", cfg_done); end
    n_cmp++; if (dout !== 2'b00) begin n_bad++; $display("FAIL reconf_dout: got %b want 00", dout); end
    for (int i = 1; i < 62; i++) begin
      if (i == 31) begin
        repeat (5) begin
          tick();
          n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL gap_done: got %b want 0", cfg_done); end
        end
      end
      shift_bit(bs_b[i]);
      n_cmp++; if (cfg_done !== (i == 61)) begin n_bad++; $display("FAIL load_b_done shift %0d: got %b want %b", i + 1, cfg_done, (i == 61)); end
    end
    // RUN entry loads init: LUT0 init=1, LUT1 init=0.
    q0 = 1'b1; q1 = 1'b0;
    exp_q.push_back({q1, q0});
    e = exp_q.pop_front();
    n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL run_entry_init: got %b want %b", dout, e); end
    ce = 1'b1;
    repeat (4) begin
      tick();
      q1 = q0; q0 = ~q0;
      exp_q.push_back({q1, q0});
      e = exp_q.pop_front();
      n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL toggle_ce1: got %b want %b", dout, e); end
    end
    ce = 1'b0;
    repeat (3) begin
      tick();
      q1 = q0;
      exp_q.push_back({q1, q0});
      e = exp_q.pop_front();
      n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL hold_ce0: got %b want %b", dout, e); end
    end
  endtask

  task automatic test_passthrough();
    logic [3:0] pats [5];
    logic [1:0] exps [5];
    logic [1:0] e;
    pats = '{4'b1111, 4'b0000, 4'b0111, 4'b0010, 4'b1000};
    exps = '{2'b10,   2'b01,   2'b10,   2'b01,   2'b00};
    for (int i = 0; i < 62; i++) begin
      shift_bit(bs_c[i]);
      n_cmp++; if (cfg_dout !== chain_q[0]) begin n_bad++; $display("FAIL load_c_cfg_dout shift %0d: got %b want %b", i + 1, cfg_dout, chain_q[0]); end
    end
    n_cmp++; if (cfg_done !== 1'b1) begin n_bad++; $display("FAIL load_c_done: got %b want 1", cfg_done); end
    for (int p = 0; p < 5; p++) begin
      din = pats[p];
      exp_q.push_back(exps[p]);
      tick();
      e = exp_q.pop_front();
      n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL cfg_c_dout din=%b: got %b want %b", pats[p], dout, e); end
    end
    // Reload A with a gap; cfg_dout replays C starting 1,0,1,1.
    n_cmp++; if (cfg_dout !== 1'b1) begin n_bad++; $display("FAIL replay_bit0: got %b want 1", cfg_dout); end
    for (int i = 0; i < 62; i++) begin
      if (i == 2) begin
        repeat (5) begin
          tick();
          n_cmp++; if (cfg_dout !== chain_q[0]) begin n_bad++; $display("FAIL gap_cfg_dout: got %b want %b", cfg_dout, chain_q[0]); end
        end
      end
      shift_bit(bs_a[i]);
      n_cmp++; if (cfg_dout !== chain_q[0]) begin n_bad++; $display("FAIL replay_cfg_dout shift %0d: got %b want %b", i + 1, cfg_dout, chain_q[0]); end
      n_cmp++; if (cfg_done !== (i == 61)) begin n_bad++; $display("FAIL replay_done shift %0d: got %b want %b", i + 1, cfg_done, (i == 61)); end
    end
    din = 4'b1011;
    exp_q.push_back(2'b01);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL reload_a_dout: got %b want %b", dout, e); end
  endtask

  task automatic test_reset_midload();
    logic [1:0] e;
    for (int i = 0; i < 30; i++) shift_bit(bs_c[i]);
    rst_n = 1'b0; cfg_en = 1'b1; cfg_din = 1'b1;
    tick();
    cfg_en = 1'b0; cfg_din = 1'b0;
    n_cmp++; if (cfg_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", cfg_done); end
    n_cmp++; if (dout !== 2'b00) begin n_bad++; $display("FAIL midrst_dout: got %b want 00", dout); end
    n_cmp++; if (cfg_dout !== 1'b0) begin n_bad++; $display("FAIL midrst_cfg_dout: got %b want 0", cfg_dout); end
    rst_n = 1'b1;
    model_reset();
    tick();
    for (int i = 0; i < 62; i++) begin
      shift_bit(bs_a[i]);
      n_cmp++; if (cfg_done !== (i == 61)) begin n_bad++; $display("FAIL post_rst_done shift %0d: got %b want %b", i + 1, cfg_done, (i == 61)); end
      n_cmp++; if (cfg_dout !== chain_q[0]) begin n_bad++; $display("FAIL post_rst_cfg_dout shift %0d: got %b want %b", i + 1, cfg_dout, chain_q[0]); end
    end
    din = 4'b1111;
    exp_q.push_back(2'b10);
    tick();
    e = exp_q.pop_front();
    n_cmp++; if (dout !== e) begin n_bad++; $display("FAIL post_rst_dout: got %b want %b", dout, e); end
  endtask

  initial begin
    // A: parity and 4-input AND, both combinational.
    bs_a = {mk_lut(16'h8000, 3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0),
            mk_lut(16'h6996, 3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0)};
    // B: LUT0 inverts its own Q (ce-gated), LUT1 copies Q0 every edge.
    bs_b = {mk_lut(16'hAAAA, 3'd4, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0),
            mk_lut(16'h5555, 3'd4, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1)};
    // C: chain bits 0-3 are 1,0,1,1; LUT1 input 3 uses out-of-range code 7.
    bs_c = {mk_lut(16'h0080, 3'd0, 3'd1, 3'd2, 3'd7, 1'b1, 1'b0, 1'b0),
            mk_lut(16'h000D, 3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0)};
    test_reset();
    test_comb_load();
    test_registered_toggle();
    test_passthrough();
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
